seq_delay_checker: RTL and testbench
====================================

SEQ_DELAY_CHECKER -- requirements
Module: seq_delay_checker

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of independent channels (legal 1..8).
REQ-002 SHALL have parameter DELAY, default 1, meaning check distance in cycles (legal 1..16).
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of each pass/fail counter (legal 4..32).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  high: a[i] may start an attempt.
REQ-007 SHALL have port clr  input  1  synchronous clear of all state.
REQ-008 SHALL have port mode  input  1  0 = fixed (a ##DELAY b), 1 = range (a ##[1:DELAY] b).
REQ-009 SHALL have port a  input  NCH  antecedent per channel.
REQ-010 SHALL have port b  input  NCH  consequent per channel.
REQ-011 SHALL have port pass  output  NCH  one-cycle pulse, at least one attempt resolved pass.
REQ-012 SHALL have port fail  output  NCH  one-cycle pulse, one attempt resolved fail.
REQ-013 SHALL have port pass_cnt  output  NCH*CNT_W  packed saturating pass counters, channel i at bits [i*CNT_W +: CNT_W].
REQ-014 SHALL have port fail_cnt  output  NCH*CNT_W  packed saturating fail counters, same packing.
REQ-015 SHALL have port sticky_fail  output  1  set by first fail on any channel.
REQ-016 SHALL have port first_fail_ch  output  max(1,$clog2(NCH))  channel index of first fail.

Function
REQ-017 SHALL start an attempt on channel i at edge k when en=1 and a[i]=1; one new attempt per channel per edge max; overlapping attempts SHALL be tracked independently (up to DELAY outstanding per channel).
REQ-018 In mode 0, an attempt started at edge k SHALL sample b[i] at edge k+DELAY only: b[i]=1 -> pass, b[i]=0 -> fail.
REQ-019 In mode 1, an attempt started at edge k SHALL resolve pass at the first edge in k+1..k+DELAY with b[i]=1; if none, fail at edge k+DELAY.
REQ-020 In mode 1, one b[i]=1 edge SHALL resolve all outstanding attempts on channel i as pass simultaneously.
REQ-021 b[i] at the start edge k SHALL NOT count toward that attempt.
REQ-022 pass[i]/fail[i] SHALL be registered: high for exactly the cycle after the resolving edge; both may be high together only in mode 1 is impossible -- pass and fail on one channel at one edge SHALL be mutually exclusive in both modes (a b[i]=1 edge yields no fail).
REQ-023 pass_cnt[i] SHALL increase by the number of attempts resolved pass at that edge (1 in mode 0; 0..DELAY in mode 1); fail_cnt[i] by 0 or 1.
REQ-024 Counters SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-025 en=0 SHALL block new attempts only; outstanding attempts SHALL continue to resolve.
REQ-026 mode SHALL apply at each edge to all outstanding attempts; a change mid-attempt takes effect at the next edge with no flush.
REQ-027 sticky_fail SHALL set at the first edge producing any fail; first_fail_ch SHALL capture the lowest-index failing channel at that edge; both SHALL hold until clr or reset.
REQ-028 DELAY=1 SHALL make modes 0 and 1 behave identically.

Reset
REQ-029 rst_n=0 SHALL immediately (asynchronously) clear outstanding attempts, pass, fail, pass_cnt, fail_cnt, sticky_fail and first_fail_ch to 0.
REQ-030 clr=1 SHALL produce the same cleared state at the edge, take priority over en/a/b at that edge (no attempt started, none resolved), and outputs SHALL be 0 in the following cycle.
REQ-031 Reset asserted mid-attempt SHALL discard the attempt with no pass/fail pulse after release.

Verification
REQ-032 NCH=4, DELAY=1, mode=0: a[0]=1 at edge 1, b[0]=1 at edge 2 -> pass[0] one cycle after edge 2, pass_cnt ch0=1, fail_cnt=0.
REQ-033 DELAY=3, mode=0: a[1]=1 at edge 1, b[1]=1 at edge 3, 0 at edge 4 -> fail[1] after edge 4, sticky_fail=1, first_fail_ch=1.
REQ-034 DELAY=3, mode=1: a[2]=1 at edges 1,2,3, b[2]=1 at edge 4 only -> single pass[2] pulse, pass_cnt ch2 +3, no fail.
REQ-035 CNT_W=4, DELAY=1, mode=0: a=b=1 on ch3 for 20 edges -> pass_cnt ch3 holds 15, no wrap.
REQ-036 DELAY=4: a[0]=1 at edge 1, rst_n low between edges 2 and 3, released before 4 -> all outputs 0 immediately, no pulse at edge 5.
REQ-037 Simultaneous fails on ch2 and ch0 at same edge -> first_fail_ch=0; later fail on ch3 leaves it 0; clr=1 -> sticky_fail=0, counters 0.

Source files
------------

// File: rtl/seq_delay_checker.sv
// Multi-channel "a then b within DELAY cycles" checker with per-channel
// pass/fail pulses, saturating counters and a sticky first-failure capture.
module seq_delay_checker #(
    parameter int NCH   = 4,
    parameter int DELAY = 1,
    parameter int CNT_W = 16,
    localparam int FW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 mode,
    input  logic [NCH-1:0]       a,
    input  logic [NCH-1:0]       b,
    output logic [NCH-1:0]       pass,
    output logic [NCH-1:0]       fail,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic                 sticky_fail,
    output logic [FW-1:0]        first_fail_ch
);

    localparam int PW = $clog2(DELAY + 1);
    localparam int SW = CNT_W + 1;

    logic [NCH-1:0] fail_now;
    logic           sticky_q, sticky_d;
    logic [FW-1:0]  ffc_q, ffc_d;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            // pend_q[j] = attempt started j+1 edges ago; the top bit is due now.
            logic [DELAY-1:0] pend_q, pend_d;
            logic [CNT_W-1:0] pcnt_q, pcnt_d, fcnt_q, fcnt_d;
            logic             pass_q, pass_d, fail_q, fail_d;
            logic [PW-1:0]    npass;
            logic             flush;
            logic [SW-1:0]    psum, fsum;

            always_comb begin
                npass  = '0;
                flush  = 1'b0;
                fail_d = 1'b0;
                if (mode && b[gi]) begin
                    flush = 1'b1;
                    for (int j = 0; j < DELAY; j++) begin
                        npass = npass + PW'(pend_q[j]);
                    end
                end else if (pend_q[DELAY-1]) begin
                    if (b[gi]) npass  = PW'(1);
                    else       fail_d = 1'b1;
                end
                pass_d = (npass != '0);

                pend_d[0] = en & a[gi];
                for (int j = 1; j < DELAY; j++) begin
                    pend_d[j] = pend_q[j-1] & ~flush;
                end

                psum   = {1'b0, pcnt_q} + SW'(npass);
                fsum   = {1'b0, fcnt_q} + SW'(fail_d);
                pcnt_d = psum[CNT_W] ? {CNT_W{1'b1}} : psum[CNT_W-1:0];
                fcnt_d = fsum[CNT_W] ? {CNT_W{1'b1}} : fsum[CNT_W-1:0];

                if (clr) begin
                    pend_d = '0;
                    pass_d = 1'b0;
                    fail_d = 1'b0;
                    pcnt_d = '0;
                    fcnt_d = '0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_q <= '0;
                    pcnt_q <= '0;
                    fcnt_q <= '0;
                    pass_q <= 1'b0;
                    fail_q <= 1'b0;
                end else begin
                    pend_q <= pend_d;
                    pcnt_q <= pcnt_d;
                    fcnt_q <= fcnt_d;
                    pass_q <= pass_d;
                    fail_q <= fail_d;
                end
            end

            assign fail_now[gi]                  = fail_d;
            assign pass[gi]                      = pass_q;
            assign fail[gi]                      = fail_q;
            assign pass_cnt[gi*CNT_W +: CNT_W]   = pcnt_q;
            assign fail_cnt[gi*CNT_W +: CNT_W]   = fcnt_q;
        end
    endgenerate

    always_comb begin
        sticky_d = sticky_q;
        ffc_d    = ffc_q;
        if (clr) begin
            sticky_d = 1'b0;
            ffc_d    = '0;
        end else if (!sticky_q && (|fail_now)) begin
            sticky_d = 1'b1;
            // Descending scan so the lowest failing index wins.
            for (int i = NCH - 1; i >= 0; i--) begin
                if (fail_now[i]) ffc_d = FW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            ffc_q    <= '0;
        end else begin
            sticky_q <= sticky_d;
            ffc_q    <= ffc_d;
        end
    end

    assign sticky_fail   = sticky_q;
    assign first_fail_ch = ffc_q;

endmodule

// File: tb/tb_seq_delay_checker.sv
// Scoreboard bench for seq_delay_checker: a queue-of-start-times reference
// model predicts each edge's outputs; a monitor compares one cycle at a time.
module tb_seq_delay_checker;

    localparam int NCH   = 4;
    localparam int DELAY = 3;
    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0, clr = 1'b0, mode = 1'b0;
    logic [NCH-1:0]       a = '0, b = '0;
    logic [NCH-1:0]       pass, fail;
    logic [NCH*CNT_W-1:0] pass_cnt, fail_cnt;
    logic                 sticky_fail;
    logic [1:0]           first_fail_ch;

    seq_delay_checker #(.NCH(NCH), .DELAY(DELAY), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
        .a(a), .b(b), .pass(pass), .fail(fail),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .sticky_fail(sticky_fail), .first_fail_ch(first_fail_ch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0]       p;
        logic [NCH-1:0]       f;
        logic [NCH*CNT_W-1:0] pc;
        logic [NCH*CNT_W-1:0] fc;
        logic                 st;
        logic [1:0]           ffc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   failures = 0;
    int   mon_cyc = 0;

    int   starts[NCH][$];
    int   edge_n = 0;
    int   m_pc[NCH];
    int   m_fc[NCH];
    bit   m_st = 0;
    int   m_ffc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < NCH; c++) begin
            starts[c].delete();
            m_pc[c] = 0;
            m_fc[c] = 0;
        end
        m_st  = 0;
        m_ffc = 0;
    endfunction

    // Every live attempt is remembered by its start edge; its age decides fate.
    function automatic exp_t model_step(bit en_, bit mode_, logic [NCH-1:0] a_,
                                        logic [NCH-1:0] b_, bit clr_, bit rst_);
        exp_t x;
        int   q[$];
        int   np;
        int   age;
        bit   f;
        int   lowf;
        x.p = '0;
        x.f = '0;
        edge_n++;
        lowf = -1;
        if (clr_ || !rst_) begin
            model_clear();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                np = 0;
                f  = 0;
                q  = {};
                foreach (starts[c][k]) begin
                    age = edge_n - starts[c][k];
                    if (mode_ && b_[c]) np++;
                    else if (age == DELAY) begin
                        if (b_[c]) np++;
                        else f = 1;
                    end else q.push_back(starts[c][k]);
                end
                starts[c] = q;
                if (en_ && a_[c]) starts[c].push_back(edge_n);
                m_pc[c] = (m_pc[c] + np > CMAX) ? CMAX : m_pc[c] + np;
                if (f) m_fc[c] = (m_fc[c] + 1 > CMAX) ? CMAX : m_fc[c] + 1;
                x.p[c] = (np > 0);
                x.f[c] = f;
                if (f && lowf < 0) lowf = c;
            end
            if (!m_st && lowf >= 0) begin
                m_st  = 1;
                m_ffc = lowf;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            x.pc[c*CNT_W +: CNT_W] = CNT_W'(m_pc[c]);
            x.fc[c*CNT_W +: CNT_W] = CNT_W'(m_fc[c]);
        end
        x.st  = m_st;
        x.ffc = 2'(m_ffc);
        return x;
    endfunction

    task automatic cyc(input bit e_, input bit m_, input logic [NCH-1:0] a_,
                       input logic [NCH-1:0] b_, input bit c_ = 0, input bit r_ = 1);
        @(negedge clk);
        en = e_; mode = m_; a = a_; b = b_; clr = c_; rst_n = r_;
        expq.push_back(model_step(e_, m_, a_, b_, c_, r_));
    endtask

    // Pull reset mid-cycle and confirm the outputs drop without a clock edge.
    task automatic reset_mid();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pass", 32'(pass), 0);
        chk("async_fail", 32'(fail), 0);
        chk("async_pcnt", 32'(pass_cnt), 0);
        chk("async_fcnt", 32'(fail_cnt), 0);
        chk("async_sticky", 32'(sticky_fail), 0);
        model_clear();
        cyc(1, 0, 4'b1111, 4'b0000, 0, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0, 1);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                mon_cyc++;
                chk("pass", 32'(pass), 32'(x.p));
                chk("fail", 32'(fail), 32'(x.f));
                chk("pass_cnt", 32'(pass_cnt), 32'(x.pc));
                chk("fail_cnt", 32'(fail_cnt), 32'(x.fc));
                chk("sticky_fail", 32'(sticky_fail), 32'(x.st));
                chk("first_fail_ch", 32'(first_fail_ch), 32'(x.ffc));
                $display("txn %0d pass=%b fail=%b pcnt=%h fcnt=%h sticky=%b ffc=%0d",
                         mon_cyc, pass, fail, pass_cnt, fail_cnt, sticky_fail, first_fail_ch);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [NCH-1:0] ra, rb;
        bit rm;
        model_clear();
        cyc(0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0, 0);
        cyc(0, 0, 4'b0000, 4'b0000, 0, 1);

        // Fixed mode: b seen early is ignored, missing at age DELAY fails.
        cyc(1, 0, 4'b0010, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0010);
        cyc(1, 0, 4'b0000, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0000);

        // Range mode: three overlapping attempts resolved by one b.
        cyc(1, 1, 4'b0100, 4'b0100);
        cyc(1, 1, 4'b0100, 4'b0000);
        cyc(1, 1, 4'b0100, 4'b0000);
        cyc(1, 1, 4'b0000, 4'b0100);
        cyc(1, 1, 4'b0000, 4'b0000);

        // Simultaneous fails on ch0/ch2, later ch3 fail, then clear.
        cyc(1, 0, 4'b0000, 4'b0000, 1);
        cyc(1, 0, 4'b0101, 4'b0000);
        cyc(1, 0, 4'b1000, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0000);
        cyc(1, 0, 4'b1111, 4'b1111, 1);
        cyc(1, 0, 4'b0000, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0000);
        cyc(1, 0, 4'b0000, 4'b0000);

        // Saturation of both counter kinds.
        repeat (40) cyc(1, 0, 4'b1111, 4'b1111);
        repeat (40) cyc(1, 0, 4'b1111, 4'b0000);
        cyc(0, 0, 4'b0000, 4'b0000, 1);

        // Attempt killed by reset must never report.
        cyc(1, 0, 4'b0001, 4'b0000);
        reset_mid();
        repeat (5) cyc(0, 0, 4'b0000, 4'b1111);

        rm = 0;
        for (int n = 0; n < 350; n++) begin
            if ($urandom_range(0, 9) == 0) rm = ~rm;
            ra = 4'($urandom);
            rb = (n < 175) ? 4'($urandom) : 4'($urandom) & 4'($urandom);
            cyc(($urandom_range(0, 7) != 0), rm, ra, rb, ($urandom_range(0, 59) == 0));
            if (n == 200) reset_mid();
        end
        cyc(0, 0, 4'b0000, 4'b0000);

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(expq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
